// File: rtl/button_gesture.sv
// button_gesture: push-button front end for the LED pattern controller.
// Synchronises and debounces the raw active-low button. It then times each
// press and the gap between presses, and classifies the gesture as a short
// click, medium hold, long hold or double click. The result is presented
// as a one-deep event with a valid/ready handshake.
//
// Ports:
//   pclk      in   system clock, all logic on the rising edge
//   presetn   in   asynchronous active-low reset
//   button_n  in   raw button, 0 = pressed, asynchronous to pclk
//   btn_level out  debounced button level, 1 = pressed
//   evt_valid out  event pending
//   evt_ready in   consumer accepts the pending event
//   evt_code  out  0 short, 1 medium, 2 long, 3 double
//   press_len out  length in cycles of the press that set the event
//   evt_ovf   out  sticky flag: an event was dropped while one was pending
module button_gesture #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned SHORT_MAX    = 100000000,
  parameter int unsigned LONG_MIN     = 250000000,
  parameter int unsigned GAP_MAX      = 25000000
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             button_n,
  output logic             btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [CNT_W-1:0] press_len,
  output logic             evt_ovf
);

  localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(LONG_MIN);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_MAX - 1);

  localparam logic [1:0] CODE_SHORT  = 2'd0;
  localparam logic [1:0] CODE_MEDIUM = 2'd1;
  localparam logic [1:0] CODE_LONG   = 2'd2;
  localparam logic [1:0] CODE_DOUBLE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS1 = 2'd1,
    ST_GAP    = 2'd2,
    ST_PRESS2 = 2'd3
  } state_t;

  // Synchroniser flops hold the raw (active-low) level; reset to released.
  logic sync_q1;
  logic sync_q2;
  logic btn_sync;

  logic [DB_W-1:0] db_cnt_q;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] press_cnt_q;
  logic [CNT_W-1:0] press_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] gap_cnt_d;
  logic [CNT_W-1:0] first_len_q;
  logic [CNT_W-1:0] first_len_d;

  logic [CNT_W-1:0] press_inc;
  logic             is_short;
  logic             is_long;

  logic             emit_c;
  logic [1:0]       emit_code_c;
  logic [CNT_W-1:0] emit_len_c;

  // Two-flop synchroniser on the raw button.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= button_n;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_sync = ~sync_q2;

  // Debounce: a new synced level must persist DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      db_cnt_q  <= '0;
      btn_level <= 1'b0;
    end else if (btn_sync == btn_level) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_q  <= '0;
      btn_level <= btn_sync;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  // Saturating press counter; a saturated count always reads as long.
  assign press_inc = (press_cnt_q == CNT_SAT) ? CNT_SAT : press_cnt_q + CNT_ONE;
  assign is_short  = (press_cnt_q < SHORT_LIM);
  assign is_long   = (press_cnt_q >= LONG_LIM) || (press_cnt_q == CNT_SAT);

  // Gesture FSM state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      first_len_q <= '0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      first_len_q <= first_len_d;
    end
  end

  // Gesture FSM next state and event generation.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    first_len_d = first_len_q;
    emit_c      = 1'b0;
    emit_code_c = CODE_SHORT;
    emit_len_c  = press_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (btn_level) begin
          state_d     = ST_PRESS1;
          press_cnt_d = CNT_ONE;
        end
      end

      ST_PRESS1: begin
        if (btn_level) begin
          press_cnt_d = press_inc;
        end else if (is_short) begin
          // A short press may be the first half of a double click.
          state_d     = ST_GAP;
          gap_cnt_d   = '0;
          first_len_d = press_cnt_q;
        end else begin
          state_d     = ST_IDLE;
          emit_c      = 1'b1;
          emit_code_c = is_long ? CODE_LONG : CODE_MEDIUM;
          emit_len_c  = press_cnt_q;
        end
      end

      ST_GAP: begin
        // A new press wins over the gap timeout in the same cycle.
        if (btn_level) begin
          state_d     = ST_PRESS2;
          press_cnt_d = CNT_ONE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d     = ST_IDLE;
          emit_c      = 1'b1;
          emit_code_c = CODE_SHORT;
          emit_len_c  = first_len_q;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_ONE;
        end
      end

      ST_PRESS2: begin
        // Second press length is reported but never changes the class.
        if (btn_level) begin
          press_cnt_d = press_inc;
        end else begin
          state_d     = ST_IDLE;
          emit_c      = 1'b1;
          emit_code_c = CODE_DOUBLE;
          emit_len_c  = press_cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One-deep event slot; a new event replaces one being accepted this cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      evt_valid <= 1'b0;
      evt_code  <= CODE_SHORT;
      press_len <= '0;
      evt_ovf   <= 1'b0;
    end else if (emit_c) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_code  <= emit_code_c;
        press_len <= emit_len_c;
      end else begin
        evt_ovf <= 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: directed and randomized stimulus for button_gesture.
// The reference model tracks the button history, how long each debounced
// press lasts and the length of each release gap. It turns those lengths
// into the expected event stream. Outputs are compared every cycle.
// Directed steps also check fixed event codes, lengths and latencies.
module tb_button_gesture;

  localparam int CNT_W   = 6;
  localparam int DEB     = 4;
  localparam int SMAX    = 20;
  localparam int LMIN    = 50;
  localparam int GMAX    = 10;
  localparam int SAT_LEN = (1 << CNT_W) - 1;

  logic             pclk      = 1'b0;
  logic             presetn   = 1'b1;
  logic             button_n  = 1'b1;
  logic             evt_ready = 1'b1;
  logic             btn_level;
  logic             evt_valid;
  logic [1:0]       evt_code;
  logic [CNT_W-1:0] press_len;
  logic             evt_ovf;

  int checks = 0;
  int errors = 0;

  // Events seen handed over at the DUT boundary: {code, length}.
  logic [CNT_W+1:0] seen[$];

  // Reference model state.
  logic       m_s1, m_s2, m_level;
  int         m_run;
  int         m_cur_len, m_first_len, m_gap;
  bit         m_pending, m_second;
  logic       m_valid, m_ovf;
  logic [1:0] m_code;
  int         m_len;

  button_gesture #(
    .CNT_W       (CNT_W),
    .DEBOUNCE_CYC(DEB),
    .SHORT_MAX   (SMAX),
    .LONG_MIN    (LMIN),
    .GAP_MAX     (GMAX)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .button_n (button_n),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .press_len(press_len),
    .evt_ovf  (evt_ovf)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_run = 0;
    m_cur_len = 0; m_first_len = 0; m_gap = 0;
    m_pending = 1'b0; m_second = 1'b0;
    m_valid = 1'b0; m_ovf = 1'b0; m_code = 2'd0; m_len = 0;
  endtask

  // One rising edge of the reference: inputs are those held since the last negedge.
  task automatic model_step();
    logic       old_sync, old_level, emit;
    logic [1:0] ecode;
    int         elen;
    old_sync  = ~m_s2;
    old_level = m_level;
    emit      = 1'b0;
    ecode     = 2'd0;
    elen      = 0;
    m_s2 = m_s1;
    m_s1 = button_n;
    // Level follows the synced button after DEB consecutive disagreeing cycles.
    if (old_sync != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = old_sync;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    // Gesture decisions from press and gap lengths.
    if (old_level) begin
      if (m_cur_len == 0 && m_pending) begin
        m_pending = 1'b0;
        m_second  = 1'b1;
      end
      if (m_cur_len < SAT_LEN) m_cur_len++;
    end else if (m_cur_len > 0) begin
      if (m_second) begin
        emit = 1'b1; ecode = 2'd3; elen = m_cur_len;
        m_second = 1'b0;
      end else if (m_cur_len < SMAX) begin
        m_pending = 1'b1; m_first_len = m_cur_len; m_gap = 0;
      end else begin
        emit = 1'b1; elen = m_cur_len;
        ecode = (m_cur_len >= LMIN || m_cur_len == SAT_LEN) ? 2'd2 : 2'd1;
      end
      m_cur_len = 0;
    end else if (m_pending) begin
      m_gap++;
      if (m_gap == GMAX) begin
        emit = 1'b1; ecode = 2'd0; elen = m_first_len;
        m_pending = 1'b0;
      end
    end
    if (emit) begin
      if (!m_valid || evt_ready) begin
        m_valid = 1'b1; m_code = ecode; m_len = elen;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("btn_level", 32'(btn_level), 32'(m_level));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("evt_code",  32'(evt_code),  32'(m_code));
    chk("press_len", 32'(press_len), 32'(m_len));
    chk("evt_ovf",   32'(evt_ovf),   32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    check_model();
    if (evt_valid === 1'b1 && evt_ready === 1'b1) seen.push_back({evt_code, press_len});
  endtask

  task automatic hold(input int n, input logic v);
    button_n = v;
    repeat (n) tick();
  endtask

  task automatic press(input int n);
    hold(n, 1'b0);
    button_n = 1'b1;
  endtask

  // Waits (bounded) for the next handed-over event; lat < 0 skips the latency check.
  task automatic expect_event(input int code, input int len, input int lat);
    int               cnt;
    logic [CNT_W+1:0] e;
    cnt = 0;
    while (seen.size() == 0 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("event_arrived", 32'(seen.size() > 0), 32'd1);
    if (seen.size() > 0) begin
      e = seen.pop_front();
      if (lat >= 0) chk("event_latency", cnt, lat);
      chk("event_code", 32'(e[CNT_W+1:CNT_W]), code);
      chk("event_len",  32'(e[CNT_W-1:0]), len);
    end
  endtask

  task automatic apply_reset();
    presetn = 1'b0;
    #1;
    model_reset();
    chk("rst_btn_level", 32'(btn_level), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_code",  32'(evt_code),  32'd0);
    chk("rst_press_len", 32'(press_len), 32'd0);
    chk("rst_evt_ovf",   32'(evt_ovf),   32'd0);
    @(negedge pclk);
    check_model();
    presetn = 1'b1;
  endtask

  initial begin
    int lo;
    int hi;
    model_reset();
    #2;
    apply_reset();
    hold(5, 1'b1);

    // Bouncing contact, then a clean 30-cycle hold.
    for (int i = 0; i < 10; i++) hold(2, (i % 2 == 0) ? 1'b0 : 1'b1);
    chk("bounce_level", 32'(btn_level), 32'd0);
    hold(5, 1'b0);
    chk("rise_before_6", 32'(btn_level), 32'd0);
    hold(1, 1'b0);
    chk("rise_at_6", 32'(btn_level), 32'd1);
    hold(24, 1'b0);
    button_n = 1'b1;
    expect_event(1, 30, 7);
    hold(5, 1'b1);

    // Single click and the hold-length boundaries.
    press(10);  expect_event(0, 10, 17); hold(5, 1'b1);
    press(60);  expect_event(2, 60, 7);  hold(5, 1'b1);
    press(20);  expect_event(1, 20, 7);  hold(5, 1'b1);
    press(19);  expect_event(0, 19, 17); hold(5, 1'b1);
    press(49);  expect_event(1, 49, 7);  hold(5, 1'b1);
    press(50);  expect_event(2, 50, 7);  hold(5, 1'b1);
    press(70);  expect_event(2, SAT_LEN, 7); hold(5, 1'b1);

    // Double click, gap just inside the window, and gap too long.
    seen.delete();
    press(8); hold(5, 1'b1); press(40);
    expect_event(3, 40, 7);
    hold(30, 1'b1);
    chk("double_single_event", 32'(seen.size()), 32'd0);
    press(8); hold(10, 1'b1); press(30);
    expect_event(3, 30, 7);
    hold(30, 1'b1);
    press(8); hold(11, 1'b1); press(30);
    expect_event(0, 8, -1);
    expect_event(1, 30, 7);
    hold(10, 1'b1);

    // Backpressure: second event is dropped and flagged.
    evt_ready = 1'b0;
    press(60); hold(10, 1'b1);
    press(30); hold(15, 1'b1);
    chk("bp_valid", 32'(evt_valid), 32'd1);
    chk("bp_code",  32'(evt_code),  32'd2);
    chk("bp_len",   32'(press_len), 32'd60);
    chk("bp_ovf",   32'(evt_ovf),   32'd1);
    evt_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(evt_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(evt_ovf),   32'd1);
    hold(5, 1'b1);

    // Reset in the middle of a held press.
    hold(10, 1'b0);
    chk("pre_reset_level", 32'(btn_level), 32'd1);
    apply_reset();
    hold(1, 1'b0);
    seen.delete();
    hold(80, 1'b1);
    chk("no_event_after_reset", 32'(seen.size()), 32'd0);

    // Random presses, gaps and glitches under random backpressure.
    for (int i = 0; i < 40; i++) begin
      lo = int'($urandom_range(1, 75));
      hi = int'($urandom_range(1, 25));
      button_n = 1'b0;
      repeat (lo) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      button_n = 1'b1;
      repeat (hi) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    evt_ready = 1'b1;
    hold(100, 1'b1);
    seen.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
